// File: rtl/zcache.sv
// Direct-mapped word cache in front of DRAM for a Z80 bus: fills from DRAM strobes,
// write-updates on hits, sweeps valid bits on flush/reset and keeps hit/miss statistics.
module zcache #(
  parameter int IDX_W = 8,
  parameter int PG_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      za,
  input  logic [PG_W-1:0]  page,
  input  logic             memrd,
  input  logic             memwr,
  input  logic             memrd_s,
  input  logic             memwr_s,
  input  logic [7:0]       wr_data,
  input  logic             ramwr_en,
  input  logic [3:0]       cache_en,
  input  logic             flush,
  input  logic             cnt_clr,
  input  logic [15:0]      cpu_rddata,
  input  logic             cpu_strobe,
  input  logic             cpu_latch,
  output logic             hit,
  output logic [7:0]       rd_data,
  output logic             flush_busy,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = PG_W + 13 - IDX_W;

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               pend_q, pend_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic [N-1:0]       valid_q, valid_d;

  logic [7:0]         lo_mem [N];
  logic [7:0]         hi_mem [N];
  logic [TAG_W-1:0]   tag_mem [N];

  logic [7:0]         lo_rd_q, hi_rd_q;
  logic [TAG_W-1:0]   tag_rd_q;
  logic               vld_rd_q;

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   cur_tag;
  logic               fill, upd, fill_we, upd_we, kill;
  logic               lo_we, hi_we;
  logic [7:0]         lo_wd, hi_wd;
  logic [15:0]        word;

  // The strobes alone mark the bus cycles; the levels are accepted for interface completeness.
  logic               unused_lvl;
  assign unused_lvl = memrd ^ memwr;

  assign idx        = za[IDX_W:1];
  assign cur_tag    = {page, za[13:IDX_W+1]};
  assign flush_busy = (state_q == S_FLUSH);
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

  always_comb begin
    hit     = (tag_rd_q == cur_tag) && vld_rd_q && cache_en[za[15:14]] && !flush_busy;
    word    = cpu_latch ? cpu_rddata : {hi_rd_q, lo_rd_q};
    rd_data = za[0] ? word[15:8] : word[7:0];
  end

  // Fill and write-update racing on the same clock leave the entry untrusted, so it is dropped.
  always_comb begin
    fill    = cpu_strobe && !flush_busy;
    upd     = memwr_s && ramwr_en && hit;
    fill_we = fill && !upd;
    upd_we  = upd && !fill;
    kill    = fill && upd;
    lo_we   = fill_we || (upd_we && !za[0]);
    hi_we   = fill_we || (upd_we && za[0]);
    lo_wd   = fill_we ? cpu_rddata[7:0]  : wr_data;
    hi_wd   = fill_we ? cpu_rddata[15:8] : wr_data;
    valid_d = valid_q;
    if (flush_busy)   valid_d[ptr_q] = 1'b0;
    else if (fill_we) valid_d[idx]   = 1'b1;
    else if (kill)    valid_d[idx]   = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pend_d  = pend_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q || flush) begin
          state_d = S_FLUSH;
          ptr_d   = '0;
          pend_d  = 1'b0;
        end
      end
      S_FLUSH: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == {IDX_W{1'b1}}) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (cnt_clr) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (memrd_s && !flush_busy) begin
      if (hit) begin
        if (!(&hit_cnt_q)) hit_cnt_d = hit_cnt_q + 1'b1;
      end else begin
        if (!(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      pend_q     <= 1'b1;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      pend_q     <= pend_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Arrays read write-first so a lookup right after a write sees the new contents.
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    if (lo_we)   lo_mem[idx]  <= lo_wd;
    if (hi_we)   hi_mem[idx]  <= hi_wd;
    if (fill_we) tag_mem[idx] <= cur_tag;
    lo_rd_q  <= lo_we   ? lo_wd   : lo_mem[idx];
    hi_rd_q  <= hi_we   ? hi_wd   : hi_mem[idx];
    tag_rd_q <= fill_we ? cur_tag : tag_mem[idx];
    vld_rd_q <= valid_d[idx];
  end

endmodule

// File: tb/tb_zcache.sv
// Directed bench for zcache: fill, write-update, misses, flush sweeps, counter saturation.
module tb_zcache;

  logic        clk = 1'b0;
  logic        rst, memrd, memwr, memrd_s, memwr_s, ramwr_en, flush, cnt_clr;
  logic        cpu_strobe, cpu_latch;
  logic [15:0] za, cpu_rddata;
  logic [7:0]  page, wr_data;
  logic [3:0]  cache_en;

  logic        hit, flush_busy, hit4, flush_busy4;
  logic [7:0]  rd_data, rd_data4;
  logic [15:0] hit_cnt, miss_cnt;
  logic [3:0]  hit_cnt4, miss_cnt4;

  int total = 0;
  int bad   = 0;
  int hit_during = 0;
  bit flush_at10 = 0;
  int n;

  always #5 clk = ~clk;

  zcache u_dut (
    .clk(clk), .rst(rst), .za(za), .page(page), .memrd(memrd), .memwr(memwr),
    .memrd_s(memrd_s), .memwr_s(memwr_s), .wr_data(wr_data), .ramwr_en(ramwr_en),
    .cache_en(cache_en), .flush(flush), .cnt_clr(cnt_clr), .cpu_rddata(cpu_rddata),
    .cpu_strobe(cpu_strobe), .cpu_latch(cpu_latch), .hit(hit), .rd_data(rd_data),
    .flush_busy(flush_busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  zcache #(.IDX_W(8), .PG_W(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .za(za), .page(page), .memrd(memrd), .memwr(memwr),
    .memrd_s(memrd_s), .memwr_s(memwr_s), .wr_data(wr_data), .ramwr_en(ramwr_en),
    .cache_en(cache_en), .flush(flush), .cnt_clr(cnt_clr), .cpu_rddata(cpu_rddata),
    .cpu_strobe(cpu_strobe), .cpu_latch(cpu_latch), .hit(hit4), .rd_data(rd_data4),
    .flush_busy(flush_busy4), .hit_cnt(hit_cnt4), .miss_cnt(miss_cnt4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a sweep to start, then counts its length while watching hit.
  task automatic count_busy(output int cnt);
    int w;
    w = 0;
    cnt = 0;
    while (!flush_busy && w < 10) begin step(); w++; end
    while (flush_busy && cnt < 2000) begin
      if (hit) hit_during++;
      flush = (flush_at10 && cnt == 10);
      step();
      cnt++;
    end
    flush = 1'b0;
  endtask

  task automatic fill_word(input logic [15:0] a, input logic [15:0] d);
    za = a; cpu_rddata = d; cpu_strobe = 1'b1;
    step();
    cpu_strobe = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; memrd = 0; memwr = 0; memrd_s = 0; memwr_s = 0; ramwr_en = 0;
    flush = 0; cnt_clr = 0; cpu_strobe = 0; cpu_latch = 0;
    za = 16'h0000; cpu_rddata = 16'h0000; page = 8'h00; wr_data = 8'h00; cache_en = 4'hF;
    repeat (3) step();
    chk("rst_busy", {31'b0, flush_busy}, 32'd0);
    chk("rst_hit_cnt", {16'b0, hit_cnt}, 32'd0);
    chk("rst_miss_cnt", {16'b0, miss_cnt}, 32'd0);
    rst = 1'b0;
    count_busy(n);
    chk("reset_sweep_len", n, 32'd256);

    page = 8'h05; za = 16'h4002;
    step();
    chk("cold_miss", {31'b0, hit}, 32'd0);
    fill_word(16'h4002, 16'hBEEF);
    za = 16'h4003;
    step();
    chk("fill_hit", {31'b0, hit}, 32'd1);
    chk("fill_hi_byte", {24'b0, rd_data}, 32'hBE);
    memrd = 1; memrd_s = 1;
    step();
    memrd = 0; memrd_s = 0;
    chk("hit_cnt_1", {16'b0, hit_cnt}, 32'd1);
    chk("miss_cnt_0", {16'b0, miss_cnt}, 32'd0);

    za = 16'h4002;
    step();
    memwr = 1; memwr_s = 1; wr_data = 8'h12; ramwr_en = 1;
    step();
    memwr = 0; memwr_s = 0;
    step();
    chk("wupd_lo", {24'b0, rd_data}, 32'h12);
    za = 16'h4003;
    step();
    chk("wupd_hi_kept", {24'b0, rd_data}, 32'hBE);
    ramwr_en = 0; memwr = 1; memwr_s = 1; wr_data = 8'h55;
    step();
    memwr = 0; memwr_s = 0;
    step();
    chk("wr_disabled", {24'b0, rd_data}, 32'hBE);

    page = 8'h06; za = 16'h4002;
    step();
    chk("page_miss", {31'b0, hit}, 32'd0);
    memrd = 1; memrd_s = 1;
    step();
    memrd = 0; memrd_s = 0;
    chk("miss_cnt_1", {16'b0, miss_cnt}, 32'd1);
    chk("hit_cnt_still_1", {16'b0, hit_cnt}, 32'd1);
    page = 8'h05; cache_en = 4'b1101;
    step();
    chk("win_disabled", {31'b0, hit}, 32'd0);
    cache_en = 4'hF;
    step();
    chk("win_enabled", {31'b0, hit}, 32'd1);

    cpu_latch = 1; cpu_rddata = 16'hA5C3; za = 16'h4003;
    step();
    chk("latch_hi", {24'b0, rd_data}, 32'hA5);
    za = 16'h4002;
    step();
    chk("latch_lo", {24'b0, rd_data}, 32'hC3);
    cpu_latch = 0;

    flush = 1;
    step();
    flush = 0;
    flush_at10 = 1;
    hit_during = 0;
    count_busy(n);
    flush_at10 = 0;
    chk("flush_len", n, 32'd256);
    chk("hit_in_flush", hit_during, 32'd0);
    step();
    chk("hit_after_flush", {31'b0, hit}, 32'd0);

    fill_word(16'h4002, 16'hBEEF);
    chk("refill_hit", {31'b0, hit}, 32'd1);
    cpu_strobe = 1; memwr = 1; memwr_s = 1; ramwr_en = 1; wr_data = 8'h77;
    step();
    cpu_strobe = 0; memwr = 0; memwr_s = 0;
    step();
    chk("collide_inval", {31'b0, hit}, 32'd0);

    cnt_clr = 1;
    step();
    cnt_clr = 0;
    chk("clr_hit", {16'b0, hit_cnt}, 32'd0);
    chk("clr_miss", {16'b0, miss_cnt}, 32'd0);
    fill_word(16'h4002, 16'hBEEF);
    chk("refill2_hit", {31'b0, hit}, 32'd1);
    memrd = 1; memrd_s = 1;
    repeat (19) step();
    memrd = 0; memrd_s = 0;
    chk("sat_hit_cnt4", {28'b0, hit_cnt4}, 32'hF);
    chk("hit_cnt_19", {16'b0, hit_cnt}, 32'd19);
    chk("sat_miss_cnt4", {28'b0, miss_cnt4}, 32'd0);
    cnt_clr = 1; memrd = 1; memrd_s = 1;
    step();
    cnt_clr = 0; memrd = 0; memrd_s = 0;
    chk("clr_wins_hit", {16'b0, hit_cnt}, 32'd0);
    chk("clr_wins_hit4", {28'b0, hit_cnt4}, 32'd0);

    flush = 1;
    step();
    flush = 0;
    repeat (20) step();
    rst = 1;
    step();
    chk("midsweep_rst_busy", {31'b0, flush_busy}, 32'd0);
    rst = 0;
    count_busy(n);
    chk("restart_len", n, 32'd256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zcache.md
ZCACHE -- requirements
Module: zcache

Interface
REQ-001 SHALL have parameter IDX_W, default 8, meaning the cache index width (2^IDX_W word entries, legal 4..12).
REQ-002 SHALL have parameter PG_W, default 8, meaning the page number width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the hit/miss counter width.
REQ-004 clk  in  1  system clock; the single clock of the block.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 za  in  16  Z80 address.
REQ-007 page  in  PG_W  current page for za[15:14].
REQ-008 memrd, memwr  in  1 each  Z80 read and write cycle levels.
REQ-009 memrd_s, memwr_s  in  1 each  one-clock start strobes of read and write cycles.
REQ-010 wr_data  in  8  Z80 write data.
REQ-011 ramwr_en  in  1  write is permitted to RAM.
REQ-012 cache_en  in  4  per-window enable, indexed by za[15:14].
REQ-013 flush, cnt_clr  in  1 each  start full invalidation; clear counters.
REQ-014 cpu_rddata  in  16  DRAM read word.
REQ-015 cpu_strobe, cpu_latch  in  1 each  DRAM fill strobe; DRAM data currently valid.
REQ-016 hit  out  1  requested address cached, valid, enabled, not flushing.
REQ-017 rd_data  out  8  byte returned to Z80.
REQ-018 flush_busy  out  1  sweep in progress.
REQ-019 hit_cnt, miss_cnt  out  CNT_W each  read statistics.

Function
REQ-020 SHALL compute index = za[IDX_W:1] and tag = {page, za[13:IDX_W+1]}, tag width PG_W+13-IDX_W.
REQ-021 SHALL hold per-entry 16-bit data, tag and valid bit; array reads are synchronous, so hit and cache data are valid 1 clk after za/page become stable.
REQ-022 hit SHALL be 1 when the stored tag equals the current tag, the entry is valid, cache_en[za[15:14]]=1 and flush_busy=0.
REQ-023 rd_data SHALL be the low byte when za[0]=0 and the high byte when za[0]=1, taken from cpu_rddata when cpu_latch=1, else from cache data.
REQ-024 On cpu_strobe (not flushing), the entry at index SHALL be written with cpu_rddata, current tag and valid=1.
REQ-025 On memwr_s with ramwr_en=1 and hit=1, only the byte lane selected by za[0] SHALL be replaced with wr_data (write-update); the other byte, tag and valid SHALL be kept.
REQ-026 memwr_s to a non-hit address, or with ramwr_en=0, SHALL leave the arrays unchanged.
REQ-027 cpu_strobe and a qualifying memwr_s in the same clock SHALL invalidate the entry (valid=0) rather than write either value.
REQ-028 SHALL implement FSM IDLE/FLUSH: flush in IDLE -> FLUSH with pointer=0 and flush_busy=1 from the next clock.
REQ-029 In FLUSH, one entry per clock SHALL be invalidated, pointer incrementing; after entry 2^IDX_W-1 -> IDLE, so flush_busy is high for exactly 2^IDX_W clocks.
REQ-030 flush asserted during FLUSH SHALL be ignored (no restart); cpu_strobe and memwr_s SHALL not write during FLUSH.
REQ-031 On memrd_s (not flushing), hit_cnt SHALL increment if hit=1, else miss_cnt SHALL increment; both counters SHALL saturate at all-ones.
REQ-032 cnt_clr SHALL zero both counters and override a simultaneous increment.

Reset
REQ-033 rst SHALL force FSM to IDLE, the pointer, hit_cnt and miss_cnt to 0, and flush_busy to 0.
REQ-034 Out of reset, every valid bit SHALL be 0: rst SHALL start the sweep of REQ-029 and flush_busy SHALL be 1 for 2^IDX_W clocks after rst is released.
REQ-035 With flush_busy=1, hit SHALL be 0; rd_data SHALL depend only on cpu_latch, cpu_rddata and the cache data array.
REQ-036 rst asserted mid-sweep SHALL restart the sweep from pointer 0.

Verification
REQ-037 Reset, wait 256 clk; page=0x05, za=0x4002, cpu_strobe with cpu_rddata=0xBEEF -> next read at 0x4003 gives hit=1, rd_data=0xBE; memrd_s -> hit_cnt=1.
REQ-038 After the fill of REQ-037, memwr_s at 0x4002 with wr_data=0x12 and ramwr_en=1 -> read at 0x4002 gives 0x12 and read at 0x4003 gives 0xBE.
REQ-039 Same index with page=0x06 -> hit=0 and memrd_s increments miss_cnt; cache_en[1]=0 with page=0x05 -> hit=0.
REQ-040 flush pulsed -> flush_busy=1 for 256 clk, hit=0 throughout and after; a second flush at clk 10 of the sweep does not extend it.
REQ-041 cpu_strobe coincident with qualifying memwr_s on a cached index -> hit=0 afterwards.
REQ-042 Drive 2^CNT_W+3 hit reads with CNT_W=4 -> hit_cnt=0xF; cnt_clr coincident with memrd_s -> hit_cnt=0.
